// File: rtl/mcu_control_sequencer.sv
`default_nettype none
// ============================================================================
// mcu_control_sequencer : fetch/decode/execute/memory control FSM for the
//                         8-bit MCU datapath; owns the PC and the IR.
// Revision 1.0
// ============================================================================
module mcu_control_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int IMM_WIDTH   = 6,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   imem_req,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [IMM_WIDTH-1:0]   imm,
    output logic                   CS,
    output logic [1:0]             alu_op,
    output logic                   alu_src_imm,
    output logic [2:0]             rd_addr,
    output logic [2:0]             rs_addr,
    output logic                   rf_we,
    output logic                   wb_sel,
    output logic                   dmem_req,
    output logic                   dmem_we,
    input  logic                   dmem_ack,
    input  logic                   zero,
    output logic                   halted,
    output logic                   illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hA;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int EXT_WIDTH = PC_WIDTH - IMM_WIDTH;

    state_t                   state;
    state_t                   state_next;
    logic [INSTR_WIDTH-1:0]   ir;
    logic [PC_WIDTH-1:0]      pc_next;
    logic [PC_WIDTH-1:0]      pc_inc;
    logic [PC_WIDTH-1:0]      pc_branch;
    logic [PC_WIDTH-1:0]      imm_sext;
    logic [3:0]               opcode;
    logic                     ir_load;
    logic                     illegal_set;
    logic                     illegal_q;

    assign opcode    = ir[15:12];
    assign imm       = ir[IMM_WIDTH-1:0];
    assign rd_addr   = ir[11:9];
    assign imm_sext  = {{EXT_WIDTH{imm[IMM_WIDTH-1]}}, imm};
    assign pc_inc    = pc + PC_WIDTH'(1);
    assign pc_branch = pc_inc + imm_sext;

    // Decoded controls come straight from the IR, so they are valid from
    // DECODE onwards and cannot change until the next fetch completes.
    always_comb begin
        CS          = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = ALU_ADD;
        rs_addr     = ir[8:6];
        case (opcode)
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            OP_ADDI: begin
                CS          = 1'b1;
                alu_src_imm = 1'b1;
            end
            OP_LDI: begin
                alu_src_imm = 1'b1;
                rs_addr     = 3'd0;
            end
            OP_LD, OP_ST: begin
                CS          = 1'b1;
                alu_src_imm = 1'b1;
            end
            OP_BEQ: begin
                CS     = 1'b1;
                alu_op = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        ir_load     = 1'b0;
        illegal_set = 1'b0;
        imem_req    = 1'b0;
        rf_we       = 1'b0;
        wb_sel      = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: begin
                        rf_we      = 1'b1;
                        pc_next    = pc_inc;
                        state_next = S_FETCH;
                    end
                    OP_NOP: begin
                        pc_next    = pc_inc;
                        state_next = S_FETCH;
                    end
                    OP_BEQ: begin
                        pc_next    = zero ? pc_branch : pc_inc;
                        state_next = S_FETCH;
                    end
                    OP_LD, OP_ST: state_next = S_MEM;
                    OP_HALT:      state_next = S_HALT;
                    default: begin
                        illegal_set = 1'b1;
                        state_next  = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_ST);
                if (dmem_ack) begin
                    rf_we      = (opcode == OP_LD);
                    wb_sel     = (opcode == OP_LD);
                    pc_next    = pc_inc;
                    state_next = S_FETCH;
                end
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // halted/illegal already show in the EXEC cycle that decides to stop.
    assign halted  = (state == S_HALT) || ((state == S_EXEC) && (state_next == S_HALT));
    assign illegal = illegal_q || illegal_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir        <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (ir_load) begin
                ir <= imem_data;
            end
            if (illegal_set) begin
                illegal_q <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mcu_control_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mcu_control_sequencer : directed program with an instruction-level model
//                            predicting every output on every cycle.
// Revision 1.0
// ============================================================================
module tb_mcu_control_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        zero = 1'b0;
    logic [15:0] imem_data = 16'hFFFF;
    logic        imem_req, CS, alu_src_imm, rf_we, wb_sel, dmem_req, dmem_we, halted, illegal;
    logic [7:0]  pc;
    logic [5:0]  imm;
    logic [1:0]  alu_op;
    logic [2:0]  rd_addr, rs_addr;

    always #5 clk = ~clk;

    mcu_control_sequencer #(.PC_WIDTH(8), .IMM_WIDTH(6), .INSTR_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .pc(pc), .imm(imm), .CS(CS), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .rd_addr(rd_addr), .rs_addr(rs_addr), .rf_we(rf_we), .wb_sel(wb_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .zero(zero), .halted(halted), .illegal(illegal)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Architectural model: last decoded instruction, PC and sticky stop flags,
    // plus the strobe pattern expected in the current cycle.
    logic [15:0] last_instr = 16'h0000;
    int exp_pc = 0;
    bit exp_imem_req, exp_dmem_req, exp_dmem_we, exp_rf_we, exp_wb_sel;
    bit exp_halted = 1'b0;
    bit exp_illegal = 1'b0;
    int cnt_imem, cnt_dreq, cnt_dwe, cnt_rfwe, cnt_wb;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int sext6(input int v);
        return (v >= 32) ? v - 64 : v;
    endfunction
    function automatic int model_cs(input int op);
        return (op == 5 || op == 7 || op == 8 || op == 9) ? 1 : 0;
    endfunction
    function automatic int model_src_imm(input int op);
        return (op == 5 || op == 6) ? 1 : 0;
    endfunction
    function automatic int model_alu_op(input int op);
        case (op)
            2: return 1;
            3: return 2;
            4: return 3;
            default: return 0;
        endcase
    endfunction
    function automatic int model_rs(input logic [15:0] ins);
        return (ins[15:12] == 4'h6) ? 0 : int'(ins[8:6]);
    endfunction
    function automatic bit writes_reg(input int op);
        return (op >= 1 && op <= 6);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_req", imem_req, exp_imem_req);
            check("dmem_req", dmem_req, exp_dmem_req);
            check("dmem_we", dmem_we, exp_dmem_we);
            check("rf_we", rf_we, exp_rf_we);
            check("wb_sel", wb_sel, exp_wb_sel);
            check("halted", halted, exp_halted);
            check("illegal", illegal, exp_illegal);
            check("pc", pc, exp_pc);
            check("imm", imm, last_instr[5:0]);
            check("rd_addr", rd_addr, last_instr[11:9]);
            check("rs_addr", rs_addr, model_rs(last_instr));
            check("CS", CS, model_cs(int'(last_instr[15:12])));
            if (last_instr[15:12] <= 4'h6) begin
                check("alu_op", alu_op, model_alu_op(int'(last_instr[15:12])));
                check("alu_src_imm", alu_src_imm, model_src_imm(int'(last_instr[15:12])));
            end
            cnt_imem += int'(imem_req);
            cnt_dreq += int'(dmem_req);
            cnt_dwe  += int'(dmem_we);
            cnt_rfwe += int'(rf_we);
            cnt_wb   += int'(wb_sel);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cnt_reset();
        cnt_imem = 0; cnt_dreq = 0; cnt_dwe = 0; cnt_rfwe = 0; cnt_wb = 0;
    endtask

    task automatic set_quiet();
        exp_imem_req = 1'b0; exp_dmem_req = 1'b0; exp_dmem_we = 1'b0;
        exp_rf_we = 1'b0; exp_wb_sel = 1'b0;
        start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; zero = 1'b0;
        imem_data = 16'hFFFF;
    endtask

    task automatic reset_and_check(input string tag);
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check({tag, "_imem_req"}, imem_req, 0);
        check({tag, "_dmem_req"}, dmem_req, 0);
        check({tag, "_dmem_we"}, dmem_we, 0);
        check({tag, "_rf_we"}, rf_we, 0);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_illegal"}, illegal, 0);
        check({tag, "_imm"}, imm, 0);
        last_instr = 16'h0000; exp_pc = 0; exp_halted = 1'b0; exp_illegal = 1'b0;
        set_quiet();
        tick();
        chk_en = 1'b1;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic mid_cycle_reset(input string tag);
        @(negedge clk);
        #2;
        reset_and_check(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_quiet(); imem_ack = 1'b1; dmem_ack = 1'b1; tick();
        end
    endtask

    task automatic do_start();
        set_quiet(); start = 1'b1; tick();
    endtask

    task automatic halt_idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_quiet(); start = i[0]; imem_ack = 1'b1; imem_data = 16'h0000; tick();
        end
    endtask

    // One instruction from its first FETCH cycle; rst_f/rst_m >= 0 abort the
    // fetch or memory wait at that cycle index with an asynchronous reset.
    task automatic run_instr(input logic [15:0] ins, input int fw, input bit zv,
                             input int mw, input int rst_f, input int rst_m);
        int op;
        op = int'(ins[15:12]);
        for (int i = 0; i <= fw; i++) begin
            set_quiet(); exp_imem_req = 1'b1; dmem_ack = 1'b1;
            if (i == rst_f) begin
                mid_cycle_reset("rst_fetch");
                return;
            end
            if (i == fw) begin
                imem_ack = 1'b1; imem_data = ins;
            end
            tick();
        end
        set_quiet(); last_instr = ins; start = 1'b1; imem_ack = 1'b1; tick();
        set_quiet(); zero = zv; dmem_ack = 1'b1; exp_rf_we = writes_reg(op);
        if (op >= 10) exp_halted = 1'b1;
        if (op >= 11) exp_illegal = 1'b1;
        tick();
        if (op >= 10) begin
            set_quiet();
            return;
        end
        if (op == 7 || op == 8) begin
            for (int i = 0; i <= mw; i++) begin
                set_quiet(); exp_dmem_req = 1'b1; exp_dmem_we = (op == 8);
                imem_ack = 1'b1; start = 1'b1;
                if (i == rst_m) begin
                    mid_cycle_reset("rst_mem");
                    return;
                end
                if (i == mw) begin
                    dmem_ack = 1'b1; exp_rf_we = (op == 7); exp_wb_sel = (op == 7);
                end
                tick();
            end
        end
        exp_pc = (exp_pc + 1 + ((op == 9 && zv) ? sext6(int'(ins[5:0])) : 0)) & 255;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        set_quiet();
        cnt_reset();
        #3;
        reset_and_check("reset");
        idle(2);
        do_start();

        cnt_reset();
        run_instr(16'h52BE, 2, 1'b0, 0, -1, -1);               // ADDI r1, r2, 0x3E
        check("addi_imem_req_cycles", cnt_imem, 3);
        check("addi_rf_we_cycles", cnt_rfwe, 1);
        check("addi_pc", pc, 1);
        check("addi_cs", CS, 1);
        check("addi_imm", imm, 6'h3E);

        cnt_reset();
        run_instr(16'h6560, 0, 1'b0, 0, -1, -1);               // LDI r2, 0x20
        check("ldi_cs", CS, 0);
        check("ldi_src_imm", alu_src_imm, 1);
        check("ldi_rs_forced", rs_addr, 0);
        check("ldi_rf_we_cycles", cnt_rfwe, 1);
        run_instr(16'h5660, 1, 1'b0, 0, -1, -1);               // ADDI r3, r1, 0x20
        check("addi2_cs", CS, 1);
        run_instr(16'h2940, 0, 1'b0, 0, -1, -1);               // SUB
        check("sub_alu_op", alu_op, 1);
        cnt_reset();
        run_instr(16'h0000, 0, 1'b0, 0, -1, -1);               // NOP
        check("nop_rf_we_cycles", cnt_rfwe, 0);
        check("nop_pc", pc, 5);

        run_instr(16'h927D, 0, 1'b1, 0, -1, -1);               // BEQ -3 taken
        check("beq_taken_pc", pc, 3);
        run_instr(16'h3A47, 0, 1'b0, 0, -1, -1);               // AND
        check("and_alu_op", alu_op, 2);
        run_instr(16'h4C8A, 1, 1'b0, 0, -1, -1);               // OR
        check("or_alu_op", alu_op, 3);
        run_instr(16'h927D, 0, 1'b0, 0, -1, -1);               // BEQ not taken
        check("beq_not_taken_pc", pc, 6);
        run_instr(16'h1E3F, 0, 1'b0, 0, -1, -1);               // ADD
        run_instr(16'h9037, 0, 1'b1, 0, -1, -1);               // BEQ -9 taken, wraps down
        check("beq_wrap_down_pc", pc, 8'hFF);
        run_instr(16'h9037, 0, 1'b0, 0, -1, -1);               // BEQ not taken at 0xFF
        check("pc_wrap_up", pc, 8'h00);

        cnt_reset();
        run_instr(16'h7A85, 1, 1'b0, 3, -1, -1);               // LD, ack after 3 waits
        check("ld_dmem_req_cycles", cnt_dreq, 4);
        check("ld_dmem_we_cycles", cnt_dwe, 0);
        check("ld_rf_we_cycles", cnt_rfwe, 1);
        check("ld_wb_sel_cycles", cnt_wb, 1);
        check("ld_pc", pc, 1);
        cnt_reset();
        run_instr(16'h8A7F, 0, 1'b0, 1, -1, -1);               // ST
        check("st_dmem_req_cycles", cnt_dreq, 2);
        check("st_dmem_we_cycles", cnt_dwe, 2);
        check("st_rf_we_cycles", cnt_rfwe, 0);
        check("st_pc", pc, 2);

        run_instr(16'h0000, 4, 1'b0, 0, 2, -1);                // reset in fetch wait
        idle(1);
        do_start();
        run_instr(16'h0000, 0, 1'b0, 0, -1, -1);
        run_instr(16'h7A85, 0, 1'b0, 5, -1, 2);                // reset in mem wait
        idle(1);
        do_start();

        run_instr(16'h0000, 0, 1'b0, 0, -1, -1);
        run_instr(16'hC123, 1, 1'b0, 0, -1, -1);               // illegal opcode
        check("illegal_halted", halted, 1);
        check("illegal_flag", illegal, 1);
        check("illegal_pc", pc, 1);
        cnt_reset();
        halt_idle(6);
        check("halt_imem_req_cycles", cnt_imem, 0);
        check("halt_sticky_illegal", illegal, 1);
        check("halt_pc", pc, 1);

        reset_and_check("reset2");
        idle(1);
        do_start();
        run_instr(16'hA000, 0, 1'b0, 0, -1, -1);               // HALT
        check("halt_op_halted", halted, 1);
        check("halt_op_illegal", illegal, 0);
        check("halt_op_pc", pc, 0);
        halt_idle(3);
        reset_and_check("reset3");
        idle(1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
